// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file widths, bus types and control constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int RF_REG_NUM      = 32;
    localparam int RF_REG_NUM_LOG2 = 5;
    localparam int RF_DATA_W       = 32;

    typedef logic [RF_DATA_W-1:0]       reg_bus_t;
    typedef logic [RF_REG_NUM_LOG2-1:0] reg_addr_bus_t;

    localparam reg_bus_t      ZERO_WORD     = '0;
    localparam reg_addr_bus_t NOP_REG_ADDR  = '0;
    localparam logic          WRITE_ENABLE  = 1'b1;
    localparam logic          WRITE_DISABLE = 1'b0;
    localparam logic          READ_ENABLE   = 1'b1;
    localparam logic          READ_DISABLE  = 1'b0;
    localparam logic          RST_ENABLE    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module      : regfile
// Description : 2-read / 1-write MIPS register file with write-to-read bypass
//               and a post-reset clear sweep of entries 1..REG_NUM-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile
    import regfile_pkg::*;
#(
    parameter int REG_NUM      = RF_REG_NUM,
    parameter int REG_NUM_LOG2 = RF_REG_NUM_LOG2,
    parameter int DATA_W       = RF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [REG_NUM_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    re1,
    input  logic [REG_NUM_LOG2-1:0] raddr1,
    output logic [DATA_W-1:0]       rdata1,
    input  logic                    re2,
    input  logic [REG_NUM_LOG2-1:0] raddr2,
    output logic [DATA_W-1:0]       rdata2,
    output logic                    init_busy
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [REG_NUM_LOG2-1:0] LAST_ADDR  = REG_NUM_LOG2'(REG_NUM - 1);
    localparam logic [REG_NUM_LOG2-1:0] FIRST_ADDR = REG_NUM_LOG2'(1);
    localparam logic [REG_NUM_LOG2-1:0] ZERO_ADDR  = '0;
    localparam logic [DATA_W-1:0]       ZERO_DATA  = '0;

    state_t                  state_q, state_d;
    logic [REG_NUM_LOG2-1:0] clr_cnt_q, clr_cnt_d;
    logic                    init_busy_q, init_busy_d;

    logic                    mem_we;
    logic [REG_NUM_LOG2-1:0] mem_waddr;
    logic [DATA_W-1:0]       mem_wdata;

    // No reset on the array so it can map onto distributed RAM.
    logic [DATA_W-1:0] mem [REG_NUM];

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_busy_d = init_busy_q;
        mem_we      = WRITE_DISABLE;
        mem_waddr   = waddr;
        mem_wdata   = wdata;

        if (rst == RST_ENABLE) begin
            state_d     = ST_INIT;
            clr_cnt_d   = FIRST_ADDR;
            init_busy_d = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // The sweep owns the write port; external writes are dropped.
                    mem_we    = WRITE_ENABLE;
                    mem_waddr = clr_cnt_q;
                    mem_wdata = ZERO_DATA;
                    clr_cnt_d = clr_cnt_q + FIRST_ADDR;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d     = ST_RUN;
                        init_busy_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (we == WRITE_ENABLE && waddr != ZERO_ADDR) begin
                        mem_we = WRITE_ENABLE;
                    end
                end
                default: begin
                    state_d     = ST_INIT;
                    clr_cnt_d   = FIRST_ADDR;
                    init_busy_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        clr_cnt_q   <= clr_cnt_d;
        init_busy_q <= init_busy_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we == WRITE_ENABLE) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Both read ports share the same priority: blocked, $0, bypass, array.
    always_comb begin
        rdata1 = ZERO_DATA;
        if (rst != RST_ENABLE && !init_busy_q && raddr1 != ZERO_ADDR
            && re1 == READ_ENABLE) begin
            if (we == WRITE_ENABLE && raddr1 == waddr) begin
                rdata1 = wdata;
            end else begin
                rdata1 = mem[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = ZERO_DATA;
        if (rst != RST_ENABLE && !init_busy_q && raddr2 != ZERO_ADDR
            && re2 == READ_ENABLE) begin
            if (we == WRITE_ENABLE && raddr2 == waddr) begin
                rdata2 = wdata;
            end else begin
                rdata2 = mem[raddr2];
            end
        end
    end

    assign init_busy = init_busy_q;

endmodule

`default_nettype wire
